// File: rtl/control_bomba_pkg.sv
// Shared types and widths for the pump controller.
package control_bomba_pkg;

    localparam int ESTADO_W = 3;
    localparam int SEG_W    = 8;
    localparam int CONF_W   = 4;

    typedef enum logic [ESTADO_W-1:0] {
        REPOSO   = 3'd0,
        CONFIRMA = 3'd1,
        RIEGO    = 3'd2,
        ESPERA   = 3'd3,
        FALLA    = 3'd4
    } estado_t;

endpackage

// File: rtl/divisor_tick.sv
// One-second prescaler: pulses tick for one cycle every CLK_HZ cycles, restartable via clr.
module divisor_tick #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = (clr || tick) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/control_bomba.sv
// Pump controller: confirms the watering request, waters, then soaks before re-evaluating.
// Optional macro MAX_CICLOS_EN adds a consecutive-cycle limit that latches a fault state.
module control_bomba
    import control_bomba_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int N_CONF     = 3,
    parameter int T_RIEGO_S  = 5,
    parameter int T_ESPERA_S = 30,
    parameter int MAX_CICLOS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                habilitar,
    input  logic                regar,
    input  logic                tanque_vacio,
    output logic                bomba,
    output logic [ESTADO_W-1:0] estado,
    output logic [SEG_W-1:0]    segundos_rest,
    output logic                falla
);

    localparam logic [CONF_W-1:0] N_CONF_V   = CONF_W'(N_CONF);
    localparam logic [SEG_W-1:0]  T_RIEGO_V  = SEG_W'(T_RIEGO_S);
    localparam logic [SEG_W-1:0]  T_ESPERA_V = SEG_W'(T_ESPERA_S);

    estado_t           state_q, state_d;
    logic [CONF_W-1:0] conf_q, conf_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              tick;
    logic              cambio;

`ifdef MAX_CICLOS_EN
    localparam logic [CONF_W-1:0] MAX_CICLOS_V = CONF_W'(MAX_CICLOS);
    logic [CONF_W-1:0] ciclos_q, ciclos_d;
`endif

    // Restarting the prescaler on every state change makes each timed state exact.
    assign cambio = (state_d != state_q);

    divisor_tick #(.CLK_HZ(CLK_HZ)) u_divisor (
        .clk  (clk),
        .rst  (rst),
        .clr  (cambio),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        conf_d  = conf_q;
        seg_d   = seg_q;
`ifdef MAX_CICLOS_EN
        ciclos_d = ciclos_q;
`endif
        unique case (state_q)
            REPOSO: begin
                conf_d = '0;
                seg_d  = '0;
`ifdef MAX_CICLOS_EN
                if (!regar) ciclos_d = '0;
`endif
                if (habilitar && regar && !tanque_vacio) state_d = CONFIRMA;
            end
            CONFIRMA: begin
                if (!habilitar || tanque_vacio || !regar) begin
                    state_d = REPOSO;
                end else if (tick) begin
                    if (conf_q + CONF_W'(1) == N_CONF_V) begin
                        state_d = RIEGO;
                        seg_d   = T_RIEGO_V;
                    end else begin
                        conf_d = conf_q + CONF_W'(1);
                    end
                end
            end
            RIEGO: begin
                if (!habilitar) begin
                    state_d = REPOSO;
                    seg_d   = '0;
                end else if (tanque_vacio) begin
                    state_d = ESPERA;
                    seg_d   = T_ESPERA_V;
                end else if (tick) begin
                    if (seg_q == SEG_W'(1)) begin
                        state_d = ESPERA;
                        seg_d   = T_ESPERA_V;
`ifdef MAX_CICLOS_EN
                        if (ciclos_q != '1) ciclos_d = ciclos_q + CONF_W'(1);
`endif
                    end else begin
                        seg_d = seg_q - SEG_W'(1);
                    end
                end
            end
            ESPERA: begin
                if (!habilitar) begin
                    state_d = REPOSO;
                    seg_d   = '0;
                end else if (tick) begin
                    if (seg_q == SEG_W'(1)) begin
                        seg_d   = '0;
                        state_d = REPOSO;
`ifdef MAX_CICLOS_EN
                        if (ciclos_q == MAX_CICLOS_V) state_d = FALLA;
`endif
                    end else begin
                        seg_d = seg_q - SEG_W'(1);
                    end
                end
            end
            FALLA: begin
                seg_d = '0;
                if (!habilitar) begin
                    state_d = REPOSO;
`ifdef MAX_CICLOS_EN
                    ciclos_d = '0;
`endif
                end
            end
            default: begin
                state_d = REPOSO;
                seg_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REPOSO;
            conf_q  <= '0;
            seg_q   <= '0;
`ifdef MAX_CICLOS_EN
            ciclos_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            conf_q  <= conf_d;
            seg_q   <= seg_d;
`ifdef MAX_CICLOS_EN
            ciclos_q <= ciclos_d;
`endif
        end
    end

    // Outputs decode directly from registers so bomba and estado move together.
    assign bomba         = (state_q == RIEGO);
    assign estado        = state_q;
    assign segundos_rest = seg_q;
`ifdef MAX_CICLOS_EN
    assign falla = (state_q == FALLA);
`else
    assign falla = 1'b0;
`endif

endmodule

// File: tb/tb_control_bomba.sv
// Bench for control_bomba: directed scenarios then random inputs, all checked against a
// time-based behavioural model of phases and elapsed cycles.
module tb_control_bomba;

    localparam int CLK_HZ     = 10;
    localparam int N_CONF     = 2;
    localparam int T_RIEGO_S  = 3;
    localparam int T_ESPERA_S = 4;
    localparam int MAX_CICLOS = 2;

    logic       clk;
    logic       rst;
    logic       habilitar;
    logic       regar;
    logic       tanque_vacio;
    logic       bomba;
    logic [2:0] estado;
    logic [7:0] segundos_rest;
    logic       falla;

    int nAsserts = 0;
    int nFail    = 0;

    // Model: phase number, cycles spent in the phase, completed consecutive waterings.
    int mPhase = 0;
    int mEl    = 0;
    int mCyc   = 0;

    control_bomba #(
        .CLK_HZ     (CLK_HZ),
        .N_CONF     (N_CONF),
        .T_RIEGO_S  (T_RIEGO_S),
        .T_ESPERA_S (T_ESPERA_S),
        .MAX_CICLOS (MAX_CICLOS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .habilitar     (habilitar),
        .regar         (regar),
        .tanque_vacio  (tanque_vacio),
        .bomba         (bomba),
        .estado        (estado),
        .segundos_rest (segundos_rest),
        .falla         (falla)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input logic r, input logic h, input logic rq, input logic tv);
        int np;
        if (r) begin
            mPhase = 0;
            mEl    = 0;
            mCyc   = 0;
            return;
        end
        np = mPhase;
        case (mPhase)
            0: begin
                if (!rq) mCyc = 0;
                if (h && rq && !tv) np = 1;
            end
            1: begin
                if (!h || tv || !rq) np = 0;
                else if (mEl + 1 == N_CONF * CLK_HZ) np = 2;
            end
            2: begin
                if (!h) np = 0;
                else if (tv) np = 3;
                else if (mEl + 1 == T_RIEGO_S * CLK_HZ) begin
                    np = 3;
                    mCyc = (mCyc < 15) ? mCyc + 1 : 15;
                end
            end
            3: begin
                if (!h) np = 0;
                else if (mEl + 1 == T_ESPERA_S * CLK_HZ) begin
                    np = 0;
`ifdef MAX_CICLOS_EN
                    if (mCyc == MAX_CICLOS) np = 4;
`endif
                end
            end
            default: begin
                if (!h) begin
                    np = 0;
                    mCyc = 0;
                end
            end
        endcase
        if (np != mPhase) mEl = 0;
        else mEl++;
        mPhase = np;
    endtask

    task automatic checkOutput();
        int expSeg;
        expSeg = 0;
        if (mPhase == 2) expSeg = T_RIEGO_S - mEl / CLK_HZ;
        if (mPhase == 3) expSeg = T_ESPERA_S - mEl / CLK_HZ;
        chk("estado", 32'(estado), 32'(mPhase));
        chk("bomba", 32'(bomba), 32'(mPhase == 2));
        chk("segundos_rest", 32'(segundos_rest), 32'(expSeg));
        chk("falla", 32'(falla), 32'(mPhase == 4));
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic applyStimulus(input logic r, input logic h, input logic rq, input logic tv);
        rst          = r;
        habilitar    = h;
        regar        = rq;
        tanque_vacio = tv;
        @(posedge clk);
        modelStep(r, h, rq, tv);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        logic regarHold;
        rst          = 1'b1;
        habilitar    = 1'b1;
        regar        = 1'b1;
        tanque_vacio = 1'b0;
        @(negedge clk);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        chk("reset_estado", 32'(estado), 32'd0);

        for (int k = 1; k <= 191; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            if (k == 1)  chk("confirma_entry", 32'(estado), 32'd1);
            if (k == 20) chk("confirma_last", 32'(estado), 32'd1);
            if (k == 21) begin
                chk("riego_entry", 32'(estado), 32'd2);
                chk("riego_seg", 32'(segundos_rest), 32'd3);
                chk("riego_bomba", 32'(bomba), 32'd1);
            end
            if (k == 50) chk("riego_last_seg", 32'(segundos_rest), 32'd1);
            if (k == 51) begin
                chk("espera_entry", 32'(estado), 32'd3);
                chk("espera_seg", 32'(segundos_rest), 32'd4);
                chk("espera_bomba", 32'(bomba), 32'd0);
            end
            if (k == 90) chk("espera_last", 32'(estado), 32'd3);
            if (k == 91) chk("reposo_after", 32'(estado), 32'd0);
`ifdef MAX_CICLOS_EN
            if (k == 182) begin
                chk("falla_estado", 32'(estado), 32'd4);
                chk("falla_flag", 32'(falla), 32'd1);
            end
`endif
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        chk("disable_estado", 32'(estado), 32'd0);
        chk("disable_falla", 32'(falla), 32'd0);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 14; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        chk("regar_drop", 32'(estado), 32'd0);

        for (int k = 1; k <= 32; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        chk("abort_estado", 32'(estado), 32'd3);
        chk("abort_seg", 32'(segundos_rest), 32'd4);
        chk("abort_bomba", 32'(bomba), 32'd0);
        for (int j = 1; j <= 40; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            if (j == 39) chk("abort_espera_last", 32'(estado), 32'd3);
            if (j == 40) chk("abort_espera_end", 32'(estado), 32'd0);
        end

        for (int k = 1; k <= 56; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        chk("espera_disable", 32'(estado), 32'd0);
        chk("espera_disable_seg", 32'(segundos_rest), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        chk("reenable_confirma", 32'(estado), 32'd1);

        regarHold = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 59) == 0) regarHold = ~regarHold;
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 149) != 0,
                          regarHold,
                          $urandom_range(0, 79) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
